// File: rtl/if_id_pipe_reg_if.sv
// Valid/ready stage bus carrying a PC and instruction word between pipeline stages.
// The producer uses the master modport and the consumer uses the slave modport.
interface if_id_pipe_reg_if #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32
);
    logic              valid;
    logic              ready;
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;

    modport master (output valid, output pc, output inst, input  ready);
    modport slave  (input  valid, input  pc, input  inst, output ready);
endinterface

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with a 2-entry skid buffer, so ready towards fetch is registered.
// Synchronous flush injects a NOP bubble. Define IF_ID_PERF_CNT_EN to add stall and flush counters.
module if_id_pipe_reg #(
    parameter int                PC_W     = 32,
    parameter int                INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013),
    parameter logic [PC_W-1:0]   RESET_PC = PC_W'(32'h0000_0000)
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    start_i,
    input  logic                    flush_i,
    if_id_pipe_reg_if.slave         fetch_if,
    if_id_pipe_reg_if.master        dec_if,
    output logic                    flushed_o
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [31:0]             stall_cnt_o,
    output logic [31:0]             flush_cnt_o
`endif
);

    // State encoding is {skid_valid, main_valid}; 2'b10 is unreachable.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b01,
        S_FULL  = 2'b11
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [PC_W-1:0]   r_main_pc;
    logic [INST_W-1:0] r_main_inst;
    logic [PC_W-1:0]   r_skid_pc;
    logic [INST_W-1:0] r_skid_inst;
    logic              r_flushed;

    logic w_main_valid;
    logic w_skid_valid;
    logic w_ready;
    logic w_accept;
    logic w_drain;
    logic w_load_main;
    logic w_load_from_skid;
    logic w_load_skid;

    assign w_main_valid = r_state[0];
    assign w_skid_valid = r_state[1];
    assign w_ready      = start_i & ~w_skid_valid;
    assign w_accept     = start_i & fetch_if.valid & w_ready;
    assign w_drain      = start_i & w_main_valid & dec_if.ready;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_load_main      = 1'b0;
        w_load_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush_i) begin
            w_state_next = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_state_next = S_ONE;
                        w_load_main  = 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_drain) begin
                        w_load_main  = 1'b1;
                    end else if (w_accept) begin
                        w_state_next = S_FULL;
                        w_load_skid  = 1'b1;
                    end else if (w_drain) begin
                        w_state_next = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_drain) begin
                        w_state_next     = S_ONE;
                        w_load_from_skid = 1'b1;
                    end
                end
                default: w_state_next = S_EMPTY;
            endcase
        end
    end

    // Payload registers; main_pc is left alone on flush so pc_o keeps its last value.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_main_pc   <= RESET_PC;
            r_main_inst <= NOP_INST;
            r_skid_pc   <= '0;
            r_skid_inst <= '0;
            r_flushed   <= 1'b0;
        end else begin
            if (w_load_main) begin
                r_main_pc   <= fetch_if.pc;
                r_main_inst <= fetch_if.inst;
            end else if (w_load_from_skid) begin
                r_main_pc   <= r_skid_pc;
                r_main_inst <= r_skid_inst;
            end
            if (w_load_skid) begin
                r_skid_pc   <= fetch_if.pc;
                r_skid_inst <= fetch_if.inst;
            end
            if (flush_i) begin
                r_flushed <= 1'b1;
            end else if (start_i) begin
                r_flushed <= 1'b0;
            end
        end
    end

    assign fetch_if.ready = w_ready;
    assign dec_if.valid   = w_main_valid;
    assign dec_if.pc      = r_main_pc;
    assign dec_if.inst    = w_main_valid ? r_main_inst : NOP_INST;
    assign flushed_o      = r_flushed;

`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic        w_stall;

    assign w_stall = start_i & w_main_valid & ~dec_if.ready;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (flush_i && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Self-checking bench for if_id_pipe_reg: directed vector table, async reset case and a
// random phase, all checked against a queue-based scoreboard of accepted entries.
module tb_if_id_pipe_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic clk;
    logic rst_n;
    logic start;
    logic flush;
    logic flushed;
`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    if_id_pipe_reg_if #(.PC_W(32), .INST_W(32)) fetch_bus ();
    if_id_pipe_reg_if #(.PC_W(32), .INST_W(32)) dec_bus ();

    if_id_pipe_reg #(
        .PC_W(32), .INST_W(32), .NOP_INST(NOP), .RESET_PC(RPC)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .start_i   (start),
        .flush_i   (flush),
        .fetch_if  (fetch_bus.slave),
        .dec_if    (dec_bus.master),
        .flushed_o (flushed)
`ifdef IF_ID_PERF_CNT_EN
        ,
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic        f;
        logic        v;
        logic [31:0] p;
        logic [31:0] ins;
        logic        r;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_flushed;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    vec_t        vt[25];
    ent_t        sb_q[$];
    logic [31:0] m_pc;
    logic        m_flushed;
    logic [31:0] m_stall;
    logic [31:0] m_fcnt;
    int          n_vec;
    int          n_err;
    int          n_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, n_cyc);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_pc      = RPC;
        m_flushed = 1'b0;
        m_stall   = '0;
        m_fcnt    = '0;
    endtask

    // One clock: drive at the negedge, check ready before the edge, update the
    // scoreboard at the edge, check registered outputs at the following negedge.
    task automatic step(input logic s, input logic f, input logic v, input logic [31:0] p,
                        input logic [31:0] ins, input logic r, output logic acc);
        logic drn;
        ent_t e;
        start          = s;
        flush          = f;
        fetch_bus.valid = v;
        fetch_bus.pc    = p;
        fetch_bus.inst  = ins;
        dec_bus.ready   = r;
        #1;
        chk("ready_o", {31'd0, fetch_bus.ready}, {31'd0, s && (sb_q.size() < 2)});
        @(posedge clk);
        acc = s && v && (sb_q.size() < 2) && !f;
        drn = s && (sb_q.size() > 0) && r;
        if (s && (sb_q.size() > 0) && !r && (m_stall != 32'hFFFF_FFFF)) m_stall++;
        if (f) begin
            sb_q.delete();
            m_flushed = 1'b1;
            if (m_fcnt != 32'hFFFF_FFFF) m_fcnt++;
        end else begin
            if (drn) void'(sb_q.pop_front());
            if (acc) begin
                e.pc   = p;
                e.inst = ins;
                sb_q.push_back(e);
            end
            if (s) m_flushed = 1'b0;
        end
        if (sb_q.size() > 0) m_pc = sb_q[0].pc;
        @(negedge clk);
        n_cyc++;
        chk("valid_o", {31'd0, dec_bus.valid}, {31'd0, sb_q.size() > 0});
        chk("pc_o", dec_bus.pc, m_pc);
        chk("inst_o", dec_bus.inst, (sb_q.size() > 0) ? sb_q[0].inst : NOP);
        chk("flushed_o", {31'd0, flushed}, {31'd0, m_flushed});
`ifdef IF_ID_PERF_CNT_EN
        chk("stall_cnt_o", stall_cnt, m_stall);
        chk("flush_cnt_o", flush_cnt, m_fcnt);
`endif
        $display("cyc %0d s=%0b f=%0b v=%0b pc_i=%h r=%0b -> valid_o=%0b pc_o=%h inst_o=%h flushed_o=%0b",
                 n_cyc, s, f, v, p, r, dec_bus.valid, dec_bus.pc, dec_bus.inst, flushed);
    endtask

    initial begin
        logic        acc;
        logic [31:0] pc_next;
        logic [31:0] inst_cur;

        n_vec = 0;
        n_err = 0;
        n_cyc = 0;

        //          s  f  v  pc_i         inst_i        r   valid pc_o         inst_o        flushed
        vt[0]  = '{1, 0, 1, 32'h100, 32'h00500093, 1,  1, 32'h100, 32'h00500093, 0};
        vt[1]  = '{1, 0, 1, 32'h104, 32'h00600113, 1,  1, 32'h104, 32'h00600113, 0};
        vt[2]  = '{1, 0, 1, 32'h108, 32'h00700193, 1,  1, 32'h108, 32'h00700193, 0};
        vt[3]  = '{1, 0, 0, 32'h000, 32'h00000000, 1,  0, 32'h108, NOP,          0};
        vt[4]  = '{1, 0, 1, 32'h100, 32'h00500093, 0,  1, 32'h100, 32'h00500093, 0};
        vt[5]  = '{1, 0, 1, 32'h104, 32'h00600113, 0,  1, 32'h100, 32'h00500093, 0};
        vt[6]  = '{1, 0, 1, 32'h108, 32'h00700193, 0,  1, 32'h100, 32'h00500093, 0};
        vt[7]  = '{1, 0, 1, 32'h108, 32'h00700193, 1,  1, 32'h104, 32'h00600113, 0};
        vt[8]  = '{1, 0, 1, 32'h108, 32'h00700193, 1,  1, 32'h108, 32'h00700193, 0};
        vt[9]  = '{1, 0, 0, 32'h000, 32'h00000000, 1,  0, 32'h108, NOP,          0};
        vt[10] = '{1, 0, 1, 32'h300, 32'h00800213, 0,  1, 32'h300, 32'h00800213, 0};
        vt[11] = '{1, 0, 1, 32'h304, 32'h00900293, 0,  1, 32'h300, 32'h00800213, 0};
        vt[12] = '{1, 1, 1, 32'h200, 32'h00a00313, 0,  0, 32'h300, NOP,          1};
        vt[13] = '{1, 0, 0, 32'h000, 32'h00000000, 1,  0, 32'h300, NOP,          0};
        vt[14] = '{1, 0, 1, 32'h400, 32'h00b00393, 0,  1, 32'h400, 32'h00b00393, 0};
        for (int k = 15; k < 20; k++)
            vt[k] = '{0, 0, 1, 32'h404, 32'h00c00413, 1,  1, 32'h400, 32'h00b00393, 0};
        vt[20] = '{1, 0, 1, 32'h404, 32'h00c00413, 1,  1, 32'h404, 32'h00c00413, 0};
        vt[21] = '{1, 0, 0, 32'h000, 32'h00000000, 1,  0, 32'h404, NOP,          0};
        vt[22] = '{0, 1, 1, 32'h500, 32'h00d00493, 1,  0, 32'h404, NOP,          1};
        vt[23] = '{0, 0, 0, 32'h000, 32'h00000000, 1,  0, 32'h404, NOP,          1};
        vt[24] = '{1, 0, 0, 32'h000, 32'h00000000, 1,  0, 32'h404, NOP,          0};

        rst_n           = 1'b0;
        start           = 1'b0;
        flush           = 1'b0;
        fetch_bus.valid = 1'b0;
        fetch_bus.pc    = '0;
        fetch_bus.inst  = '0;
        dec_bus.ready   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        #1;
        chk("rst_valid_o", {31'd0, dec_bus.valid}, 32'd0);
        chk("rst_pc_o", dec_bus.pc, RPC);
        chk("rst_inst_o", dec_bus.inst, NOP);
        chk("rst_flushed_o", {31'd0, flushed}, 32'd0);
        chk("rst_ready_o", {31'd0, fetch_bus.ready}, 32'd1);
        @(negedge clk);

        for (int i = 0; i < 25; i++) begin
            step(vt[i].s, vt[i].f, vt[i].v, vt[i].p, vt[i].ins, vt[i].r, acc);
            chk("tbl_valid_o", {31'd0, dec_bus.valid}, {31'd0, vt[i].e_valid});
            chk("tbl_pc_o", dec_bus.pc, vt[i].e_pc);
            chk("tbl_inst_o", dec_bus.inst, vt[i].e_inst);
            chk("tbl_flushed_o", {31'd0, flushed}, {31'd0, vt[i].e_flushed});
        end
`ifdef IF_ID_PERF_CNT_EN
        chk("tbl_stall_cnt", stall_cnt, 32'd4);
        chk("tbl_flush_cnt", flush_cnt, 32'd2);
`endif

        // Fill to FULL, then drop reset between edges.
        step(1, 0, 1, 32'h600, 32'h00e00513, 0, acc);
        step(1, 0, 1, 32'h604, 32'h00f00593, 0, acc);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid_o", {31'd0, dec_bus.valid}, 32'd0);
        chk("arst_pc_o", dec_bus.pc, RPC);
        chk("arst_inst_o", dec_bus.inst, NOP);
        chk("arst_ready_o", {31'd0, fetch_bus.ready}, 32'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        pc_next  = 32'h1000;
        inst_cur = $urandom;
        for (int i = 0; i < 300; i++) begin
            step(($urandom % 10) != 0, ($urandom % 20) == 0, ($urandom % 4) != 0,
                 pc_next, inst_cur, ($urandom % 3) != 0, acc);
            if (acc) begin
                pc_next  = pc_next + 32'd4;
                inst_cur = $urandom;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
